dpll_core: RTL and testbench

Parametrised all-digital phase-locked loop core, the single-clock successor of the team's XOR/K-counter/ID-counter/divide-by-N PLL. Every stage runs on `clk` with clock enables; no derived clocks. Generic widths, selectable phase detector (XOR or edge-triggered JK), runtime loop-filter modulus, frequency lock detection and input-period measurement. Sits between the external reference input `fin` and downstream logic that consumes the locked `fout`.

---
 rtl/dpll_core_if.sv | 26 ++
 rtl/dpll_core.sv | 185 ++++++++++++++++++
 tb/tb_dpll_core.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dpll_core_if.sv
// Signal bundle between the DPLL core and the logic that drives its reference and control inputs.
// The master side drives the reference and loop controls; the slave side is the core.
interface dpll_core_if #(
    parameter int N_W = 16,
    parameter int P_W = 20
);
    logic           enable;
    logic           fin;
    logic [2:0]     kmode;
    logic           pd_mode;
    logic [N_W-1:0] n_div;
    logic           fout;
    logic           se;
    logic           locked;
    logic [P_W-1:0] fin_period;

    modport master (
        output enable, fin, kmode, pd_mode, n_div,
        input  fout, se, locked, fin_period
    );

    modport slave (
        input  enable, fin, kmode, pd_mode, n_div,
        output fout, se, locked, fin_period
    );
endinterface

// File: rtl/dpll_core.sv
// Single-clock all-digital PLL: phase detector, K up/down counter, increment/decrement counter,
// divide-by-N feedback, fin period measurement and frequency lock detection.
module dpll_core #(
    parameter int N_W    = 16,
    parameter int P_W    = 20,
    parameter int LOCK_N = 8
) (
    input logic        clk,
    input logic        reset,
    dpll_core_if.slave bus
);
    localparam int K_W = 9;
    localparam int G_W = $clog2(LOCK_N + 1);
    localparam logic [P_W-1:0] P_MAX    = '1;
    localparam logic [G_W-1:0] GOOD_MAX = G_W'(LOCK_N);

    // Input conditioning and edge pulses
    logic fin_m, fin_s, fin_s_q, fin_re;
    logic fout_r, fout_q, fout_re;

    // Phase detector and K counter
    logic           se_r;
    logic [K_W-1:0] kcnt;
    logic [K_W-1:0] kmax;
    logic           carry, borrow;

    // ID counter
    logic t, inc_pend, dec_pend;
    logic both, ins, del, id_en;

    // Divider
    logic [N_W-1:0] dcnt;
    logic [N_W-1:0] n_eff;

    // Measurement and lock detection
    logic [P_W-1:0] pcnt;
    logic [P_W-1:0] fin_period_r;
    logic [1:0]     fcnt;
    logic           primed;
    logic [G_W-1:0] good;
    logic           locked_r;

    always_comb begin
        // NOTE: every always_comb output is assigned on every path so no latch is inferred.
        kmax  = K_W'((10'd4 << bus.kmode) - 10'd1);
        n_eff = (bus.n_div == '0) ? N_W'(1) : bus.n_div;
        both  = inc_pend & dec_pend;
        ins   = inc_pend & ~dec_pend & ~t;
        del   = dec_pend & ~inc_pend & t;
        id_en = (t & ~del) | ins;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            fin_m   <= 1'b0;
            fin_s   <= 1'b0;
            fin_s_q <= 1'b0;
            fin_re  <= 1'b0;
            fout_q  <= 1'b0;
            fout_re <= 1'b0;
        end else begin
            fin_m   <= bus.fin;
            fin_s   <= fin_m;
            fin_s_q <= fin_s;
            fin_re  <= fin_s & ~fin_s_q;
            fout_q  <= fout_r;
            fout_re <= fout_r & ~fout_q;
        end
    end

    // JK mode holds se when both edges land in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            se_r <= 1'b0;
        end else if (!bus.pd_mode) begin
            se_r <= fin_s ^ fout_r;
        end else if (fin_re && !fout_re) begin
            se_r <= 1'b1;
        end else if (fout_re && !fin_re) begin
            se_r <= 1'b0;
        end
    end

    // An out-of-range count after a kmode change is cleared before any counting
    always_ff @(posedge clk) begin
        if (reset) begin
            kcnt   <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            carry  <= 1'b0;
            borrow <= 1'b0;
            if (kcnt > kmax) begin
                kcnt <= '0;
            end else if (bus.enable) begin
                if (!se_r) begin
                    if (kcnt == kmax) begin
                        kcnt  <= '0;
                        carry <= 1'b1;
                    end else begin
                        kcnt <= kcnt + K_W'(1);
                    end
                end else begin
                    if (kcnt == '0) begin
                        kcnt   <= kmax;
                        borrow <= 1'b1;
                    end else begin
                        kcnt <= kcnt - K_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t        <= 1'b0;
            inc_pend <= 1'b0;
            dec_pend <= 1'b0;
        end else begin
            t        <= ~t;
            inc_pend <= carry  | (inc_pend & ~ins & ~both);
            dec_pend <= borrow | (dec_pend & ~del & ~both);
        end
    end

    // Comparing with >= lets a lowered n_div take effect on the very next id_en
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt   <= '0;
            fout_r <= 1'b0;
        end else if (id_en) begin
            if (dcnt >= n_eff - N_W'(1)) begin
                dcnt   <= '0;
                fout_r <= ~fout_r;
            end else begin
                dcnt <= dcnt + N_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt         <= '0;
            fin_period_r <= '0;
        end else if (fin_re) begin
            pcnt         <= '0;
            fin_period_r <= (pcnt == P_MAX) ? P_MAX : pcnt + P_W'(1);
        end else if (pcnt != P_MAX) begin
            pcnt <= pcnt + P_W'(1);
        end
    end

    // The first reference edge only opens a window; it has nothing to be judged against
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt     <= '0;
            primed   <= 1'b0;
            good     <= '0;
            locked_r <= 1'b0;
        end else if (fin_re) begin
            fcnt   <= '0;
            primed <= 1'b1;
            if (primed) begin
                if (fcnt == 2'd1) begin
                    good <= (good == GOOD_MAX) ? good : good + G_W'(1);
                    if (good >= GOOD_MAX - G_W'(1)) begin
                        locked_r <= 1'b1;
                    end
                end else begin
                    good     <= '0;
                    locked_r <= 1'b0;
                end
            end
        end else if (fout_re && fcnt != 2'd3) begin
            fcnt <= fcnt + 2'd1;
        end
    end

    assign bus.fout       = fout_r;
    assign bus.se         = se_r;
    assign bus.locked     = locked_r;
    assign bus.fin_period = fin_period_r;
endmodule

// File: tb/tb_dpll_core.sv
// Self-checking bench for dpll_core: free-run table, period measurement, K/ID counter behaviour,
// XOR lock acquisition, lock loss/reacquisition and boundary cases.
module tb_dpll_core;
    localparam int N_W    = 16;
    localparam int P_W    = 12;
    localparam int LOCK_N = 8;
    localparam int P_SAT  = (1 << P_W) - 1;

    logic clk;
    logic reset;

    dpll_core_if #(.N_W(N_W), .P_W(P_W)) bus ();

    dpll_core #(.N_W(N_W), .P_W(P_W), .LOCK_N(LOCK_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int n;
        int half;
    } fr_vec_t;

    int   n_pass, n_checks;
    int   fin_per, fin_ph;
    logic fin_rise, fout_prev;
    int   fout_rises, borrows, carries, id_ens;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_half(input int n);
        return 2 * ((n < 1) ? 1 : n);
    endfunction

    function automatic int ref_period(input int p);
        return (p > P_SAT) ? P_SAT : p;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // One clock: sample at the falling edge, then drive fin for the next cycle
    task automatic step();
        @(negedge clk);
        if (bus.fout && !fout_prev) fout_rises++;
        fout_prev = bus.fout;
        if (dut.borrow) borrows++;
        if (dut.carry)  carries++;
        if (dut.id_en)  id_ens++;
        fin_rise = 1'b0;
        if (fin_per != 0) begin
            bus.fin  = (fin_ph < fin_per / 2);
            fin_rise = (fin_ph == 0);
            fin_ph   = (fin_ph + 1) % fin_per;
        end
    endtask

    task automatic clear_counts();
        fout_rises = 0; borrows = 0; carries = 0; id_ens = 0;
    endtask

    task automatic apply_reset();
        fin_per = 0;
        bus.fin = 1'b0;
        reset   = 1'b1;
        repeat (3) step();
        reset   = 1'b0;
    endtask

    task automatic wait_rise(input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!fin_rise && n < limit);
    endtask

    task automatic measure_half(output int half);
        logic f0;
        int   n;
        f0 = bus.fout; n = 0;
        while (bus.fout == f0 && n < 300) begin step(); n++; end
        f0 = bus.fout; n = 0;
        while (bus.fout == f0 && n < 300) begin step(); n++; end
        half = n;
    endtask

    initial begin
        fr_vec_t tbl[5];
        int      half, p, n, early, drops;

        n_pass = 0; n_checks = 0;
        fin_per = 0; fin_ph = 0; fin_rise = 1'b0; fout_prev = 1'b0;
        clear_counts();
        bus.enable = 1'b0; bus.fin = 1'b0; bus.kmode = 3'd0; bus.pd_mode = 1'b0; bus.n_div = 16'd4;
        reset = 1'b1;

        tbl[0] = '{n: 0, half: 2};
        tbl[1] = '{n: 1, half: 2};
        tbl[2] = '{n: 4, half: 8};
        tbl[3] = '{n: 3, half: 6};
        tbl[4] = '{n: 9, half: 18};

        // Reset and free-run at centre frequency
        repeat (3) step();
        check("reset_fout", bus.fout, 0);
        check("reset_se", bus.se, 0);
        check("reset_locked", bus.locked, 0);
        check("reset_fin_period", bus.fin_period, 0);
        reset = 1'b0;
        measure_half(half);
        check("freerun_half_n4", half, 8);
        check("freerun_locked", bus.locked, 0);
        check("freerun_fin_period", bus.fin_period, 0);

        foreach (tbl[i]) begin
            bus.n_div = N_W'(tbl[i].n);
            apply_reset();
            measure_half(half);
            check($sformatf("table_half_n%0d", tbl[i].n), half, tbl[i].half);
        end

        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(1, 30);
            bus.n_div = N_W'(n);
            apply_reset();
            measure_half(half);
            check($sformatf("rand_half_n%0d", n), half, ref_half(n));
        end

        // Period measurement
        bus.n_div = 16'd4;
        apply_reset();
        fin_per = 100; fin_ph = 0;
        for (int i = 0; i < 4; i++) begin
            wait_rise(200);
            repeat (4) step();
            if (i >= 1) check($sformatf("period100_%0d", i), bus.fin_period, 100);
        end
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(8, 600);
            wait_rise(700);
            fin_per = p;
            wait_rise(p + 5);
            repeat (4) step();
            check($sformatf("rand_period_%0d", p), bus.fin_period, ref_period(p));
        end
        fin_per = 0;
        bus.fin = 1'b0;
        repeat (P_SAT + 100) step();
        fin_per = 50; fin_ph = 0;
        step();
        repeat (4) step();
        check("period_saturated", bus.fin_period, P_SAT);

        // Reset mid-operation
        reset = 1'b1;
        step();
        check("midreset_fout", bus.fout, 0);
        check("midreset_se", bus.se, 0);
        check("midreset_locked", bus.locked, 0);
        check("midreset_fin_period", bus.fin_period, 0);
        reset = 1'b0;

        // Borrow path: JK detector held high, fout parked by a huge divide ratio
        bus.n_div = '1; bus.kmode = 3'd0; bus.pd_mode = 1'b1; bus.enable = 1'b1;
        apply_reset();
        bus.fin = 1'b1;
        repeat (10) step();
        check("jk_se_high", bus.se, 1);
        clear_counts();
        repeat (400) step();
        check("borrow_count", borrows, 100);
        check("borrow_no_carry", carries, 0);
        check_range("id_en_deleted", id_ens, 99, 101);

        // Carry path: XOR detector with both inputs low
        bus.pd_mode = 1'b0;
        apply_reset();
        repeat (10) step();
        clear_counts();
        repeat (400) step();
        check("carry_count", carries, 100);
        check("carry_no_borrow", borrows, 0);
        check_range("id_en_inserted", id_ens, 299, 301);

        // kmode shrink with kcnt beyond the new modulus
        bus.kmode = 3'd7;
        apply_reset();
        n = 0;
        do begin step(); n++; end while (dut.kcnt != 300 && n < 600);
        bus.kmode = 3'd0;
        clear_counts();
        step();
        check("kmode_shrink_kcnt", dut.kcnt, 0);
        check("kmode_shrink_pulses", carries + borrows, 0);

        // XOR lock at fin period 18
        bus.kmode = 3'd2; bus.n_div = 16'd4; bus.pd_mode = 1'b0; bus.enable = 1'b1;
        apply_reset();
        fin_per = 18; fin_ph = 0;
        n = 0;
        while (!bus.locked && n < 200 * 18) begin step(); n++; end
        check("xor_lock_acquired", bus.locked, 1);
        clear_counts();
        drops = 0;
        repeat (40 * 18) begin
            step();
            if (!bus.locked) drops++;
        end
        check("xor_lock_held", drops, 0);
        check_range("xor_fout_avg", fout_rises, 39, 41);

        // Lock loss on a 40-clk period, then reacquisition at 18
        wait_rise(40);
        fin_per = 40;
        repeat (39) step();
        step();
        check("long_period_rise", fin_rise, 1);
        repeat (3) step();
        check("lock_before_loss", bus.locked, 1);
        step();
        check("lock_lost", bus.locked, 0);
        fin_per = 18;
        early = 0;
        repeat (140) begin
            step();
            if (bus.locked) early++;
        end
        check("relock_not_early", early, 0);
        n = 0;
        while (!bus.locked && n < 200 * 18) begin step(); n++; end
        check("relock_acquired", bus.locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
